inst_encoder: RTL

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: two-stage valid/ready pipeline, fields in, word out.
// Immediate range checking is compiled in with INST_ENCODER_RANGE_CHECK_EN.
module inst_encoder #(
  parameter int ILLEGAL_ZERO = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err
);

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B,
    FMT_U, FMT_J, FMT_X
  } fmt_e;

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    fmt_e        fmt;
    logic        shamt;
  } s1_t;

  logic        r_s1_valid;
  s1_t         r_s1;
  logic        r_s2_valid;
  logic [31:0] r_s2_inst;
  logic        r_s2_err;

  logic        w_s2_move;
  logic        w_in_fire;
  fmt_e        w_fmt;
  logic        w_shamt;
  logic [31:0] w_pack;
  logic        w_err;

  logic w_op_r, w_op_imm, w_op_ld, w_op_jalr;
  logic w_op_s, w_op_b, w_op_lui, w_op_auipc, w_op_jal;

  assign w_s2_move = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_move;
  assign w_in_fire = in_valid && in_ready;

  assign out_valid = r_s2_valid;
  assign out_inst  = r_s2_inst;
  assign out_err   = r_s2_err;

  assign w_op_r     = opcode == 7'b0110011;
  assign w_op_imm   = opcode == 7'b0010011;
  assign w_op_ld    = opcode == 7'b0000011;
  assign w_op_jalr  = opcode == 7'b1100111;
  assign w_op_s     = opcode == 7'b0100011;
  assign w_op_b     = opcode == 7'b1100011;
  assign w_op_lui   = opcode == 7'b0110111;
  assign w_op_auipc = opcode == 7'b0010111;
  assign w_op_jal   = opcode == 7'b1101111;

  always_comb begin
    w_fmt = FMT_X;
    unique case (1'b1)
      w_op_r:                        w_fmt = FMT_R;
      w_op_imm, w_op_ld, w_op_jalr:  w_fmt = FMT_I;
      w_op_s:                        w_fmt = FMT_S;
      w_op_b:                        w_fmt = FMT_B;
      w_op_lui, w_op_auipc:          w_fmt = FMT_U;
      w_op_jal:                      w_fmt = FMT_J;
      default:                       w_fmt = FMT_X;
    endcase
  end

  // SLLI/SRLI/SRAI carry funct7 above a 5-bit shift amount
  assign w_shamt = w_op_imm &&
    (funct3 == 3'b001 || funct3 == 3'b101);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else begin
      if (in_ready)
        r_s1_valid <= in_valid;
      if (w_in_fire) begin
        r_s1.op    <= opcode;
        r_s1.rd    <= rd;
        r_s1.rs1   <= rs1;
        r_s1.rs2   <= rs2;
        r_s1.f3    <= funct3;
        r_s1.f7    <= funct7;
        r_s1.imm   <= imm;
        r_s1.fmt   <= w_fmt;
        r_s1.shamt <= w_shamt;
      end
    end
  end

`ifdef INST_ENCODER_RANGE_CHECK_EN
  logic w_i_ok, w_sh_ok, w_b_ok, w_j_ok, w_u_ok;
  assign w_i_ok  = &r_s1.imm[31:11] | ~|r_s1.imm[31:11];
  assign w_sh_ok = ~|r_s1.imm[31:5];
  assign w_b_ok  = (&r_s1.imm[31:12] | ~|r_s1.imm[31:12])
                   & ~r_s1.imm[0];
  assign w_j_ok  = (&r_s1.imm[31:20] | ~|r_s1.imm[31:20])
                   & ~r_s1.imm[0];
  assign w_u_ok  = ~|r_s1.imm[11:0];
`endif

  always_comb begin
    w_pack = '0;
    w_err  = 1'b0;
    unique case (r_s1.fmt)
      FMT_R: w_pack = {r_s1.f7, r_s1.rs2, r_s1.rs1,
                       r_s1.f3, r_s1.rd, r_s1.op};
      FMT_I: begin
        if (r_s1.shamt)
          w_pack = {r_s1.f7, r_s1.imm[4:0], r_s1.rs1,
                    r_s1.f3, r_s1.rd, r_s1.op};
        else
          w_pack = {r_s1.imm[11:0], r_s1.rs1,
                    r_s1.f3, r_s1.rd, r_s1.op};
`ifdef INST_ENCODER_RANGE_CHECK_EN
        w_err = r_s1.shamt ? !w_sh_ok : !w_i_ok;
`endif
      end
      FMT_S: begin
        w_pack = {r_s1.imm[11:5], r_s1.rs2, r_s1.rs1,
                  r_s1.f3, r_s1.imm[4:0], r_s1.op};
`ifdef INST_ENCODER_RANGE_CHECK_EN
        w_err = !w_i_ok;
`endif
      end
      FMT_B: begin
        w_pack = {r_s1.imm[12], r_s1.imm[10:5], r_s1.rs2,
                  r_s1.rs1, r_s1.f3, r_s1.imm[4:1],
                  r_s1.imm[11], r_s1.op};
`ifdef INST_ENCODER_RANGE_CHECK_EN
        w_err = !w_b_ok;
`endif
      end
      FMT_U: begin
        w_pack = {r_s1.imm[31:12], r_s1.rd, r_s1.op};
`ifdef INST_ENCODER_RANGE_CHECK_EN
        w_err = !w_u_ok;
`endif
      end
      FMT_J: begin
        w_pack = {r_s1.imm[20], r_s1.imm[10:1],
                  r_s1.imm[11], r_s1.imm[19:12],
                  r_s1.rd, r_s1.op};
`ifdef INST_ENCODER_RANGE_CHECK_EN
        w_err = !w_j_ok;
`endif
      end
      default: begin
        w_pack = (ILLEGAL_ZERO != 0) ? 32'h0
                                     : {25'b0, r_s1.op};
        w_err  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_inst  <= '0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_move) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_inst <= w_pack;
        r_s2_err  <= w_err;
      end
    end
  end

endmodule
